// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg : shared encodings and packed-state field offsets for enemy_walker
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package enemy_pkg;

   typedef enum logic [1:0] {
      FSM_WALK  = 2'd0,
      FSM_TURN  = 2'd1,
      FSM_FALL  = 2'd2,
      FSM_DYING = 2'd3
   } fsm_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int COL_LEFT   = 0;
   localparam int COL_RIGHT  = 1;
   localparam int COL_LEDGE  = 2;
   localparam int COL_GROUND = 3;

   localparam int ALIVE_BIT = 0;
   localparam int DIR_BIT   = 1;
   localparam int FSM_LSB   = 5;
   localparam int SPD_LSB   = 7;

   function automatic int y_lsb(input int spd_w);
      return spd_w + SPD_LSB;
   endfunction

   function automatic int x_lsb(input int pos_w, input int spd_w);
      return pos_w + spd_w + SPD_LSB;
   endfunction

   function automatic int state_width(input int pos_w, input int spd_w);
      return 2 * pos_w + spd_w + SPD_LSB;
   endfunction

   // Counter only ever holds (frames - 1), so clog2 of the larger count suffices.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_walker_tile_snap.sv
// ---------------------------------------------------------------------------
// tile_snap : moves a position by +/- speed and derives the grid-snapped values
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tile_snap
   import enemy_pkg::*;
#(
   parameter int POS_W     = 10,
   parameter int SPD_W     = 5,
   parameter int TILE_LOG2 = 5
) (
   input  logic [POS_W-1:0] pos,
   input  logic [SPD_W-1:0] spd,
   input  logic             dir,
   output logic [POS_W-1:0] moved,
   output logic [POS_W-1:0] snapped,
   output logic [POS_W-1:0] aligned
);

   localparam logic [POS_W-1:0] TILE = POS_W'(1) << TILE_LOG2;
   localparam logic [POS_W-1:0] MASK = TILE - POS_W'(1);

   logic [POS_W-1:0] frac;

   // Wall snap: heading right lands one pixel short of the tile boundary,
   // heading left lands on the next boundary up.
   always_comb begin
      moved   = (dir == DIR_RIGHT) ? pos + POS_W'(spd) : pos - POS_W'(spd);
      frac    = moved & MASK;
      snapped = (dir == DIR_RIGHT) ? moved - frac - POS_W'(1) : moved + (TILE - frac);
      aligned = moved & ~MASK;
   end

endmodule

`default_nettype wire

// File: rtl/enemy_walker.sv
// ---------------------------------------------------------------------------
// enemy_walker : per-enemy walk / turn-pause / fall / stomp-death state machine
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enemy_walker
   import enemy_pkg::*;
#(
   parameter int POS_W        = 10,
   parameter int SPD_W        = 5,
   parameter int TILE_LOG2    = 5,
   parameter int LEDGE_TURN   = 0,
   parameter int TURN_PAUSE   = 8,
   parameter int GRAVITY      = 1,
   parameter int MAX_FALL     = 8,
   parameter int DEATH_FRAMES = 16,
   parameter int INIT_X       = 200,
   parameter int INIT_Y       = 150,
   parameter int INIT_SPD     = 3,
   localparam int STATE_W     = 2 * POS_W + SPD_W + 7
) (
   input  logic               sim_clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               load,
   input  logic [STATE_W-1:0] init_state,
   input  logic [3:0]         col,
   input  logic               stomp,
   output logic [STATE_W-1:0] enemy_state,
   output logic               alive,
   output logic [1:0]         fsm_state
);

   localparam int X_LSB = x_lsb(POS_W, SPD_W);
   localparam int Y_LSB = y_lsb(SPD_W);
   localparam int VY_W  = (MAX_FALL > 0) ? $clog2(MAX_FALL + 1) : 1;
   localparam int CNT_W = cnt_width(TURN_PAUSE, DEATH_FRAMES);

   localparam logic LEDGE_EN = (LEDGE_TURN != 0);
   localparam logic PAUSE_EN = (TURN_PAUSE != 0);
   localparam logic [CNT_W-1:0] TURN_LOAD  = (TURN_PAUSE > 0) ? CNT_W'(TURN_PAUSE - 1) : '0;
   localparam logic [CNT_W-1:0] DEATH_LOAD = (DEATH_FRAMES > 0) ? CNT_W'(DEATH_FRAMES - 1) : '0;

   logic [POS_W-1:0] pos_x, pos_y, x_nxt, y_nxt;
   logic [SPD_W-1:0] speed, spd_nxt;
   logic             dir, dir_nxt;
   fsm_t             fsm, fsm_nxt;
   logic [VY_W-1:0]  vy, vy_nxt, vy_inc;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             is_alive, alive_nxt;
   logic [31:0]      vy_sum;
   logic             wall_hit;

   logic [POS_W-1:0] x_moved, x_snapped, x_aligned_unused;
   logic [POS_W-1:0] y_land, y_moved_unused, y_snapped_unused;
   logic             unused_init;

   assign unused_init = ^{init_state[SPD_LSB-1:DIR_BIT+1], init_state[ALIVE_BIT]};

   tile_snap #(
      .POS_W     (POS_W),
      .SPD_W     (SPD_W),
      .TILE_LOG2 (TILE_LOG2)
   ) u_snap_x (
      .pos     (pos_x),
      .spd     (speed),
      .dir     (dir),
      .moved   (x_moved),
      .snapped (x_snapped),
      .aligned (x_aligned_unused)
   );

   // Zero-speed instance: its aligned output is the landing row for y.
   tile_snap #(
      .POS_W     (POS_W),
      .SPD_W     (SPD_W),
      .TILE_LOG2 (TILE_LOG2)
   ) u_snap_y (
      .pos     (pos_y),
      .spd     ('0),
      .dir     (DIR_RIGHT),
      .moved   (y_moved_unused),
      .snapped (y_snapped_unused),
      .aligned (y_land)
   );

   assign wall_hit = col[COL_LEFT] | col[COL_RIGHT] | (LEDGE_EN & col[COL_LEDGE]);

   always_ff @(posedge sim_clk or negedge reset) begin
      if (!reset) begin
         pos_x    <= POS_W'(INIT_X);
         pos_y    <= POS_W'(INIT_Y);
         speed    <= SPD_W'(INIT_SPD);
         dir      <= DIR_RIGHT;
         fsm      <= FSM_WALK;
         vy       <= '0;
         cnt      <= '0;
         is_alive <= 1'b1;
      end else begin
         pos_x    <= x_nxt;
         pos_y    <= y_nxt;
         speed    <= spd_nxt;
         dir      <= dir_nxt;
         fsm      <= fsm_nxt;
         vy       <= vy_nxt;
         cnt      <= cnt_nxt;
         is_alive <= alive_nxt;
      end
   end

   always_comb begin
      x_nxt     = pos_x;
      y_nxt     = pos_y;
      spd_nxt   = speed;
      dir_nxt   = dir;
      fsm_nxt   = fsm;
      vy_nxt    = vy;
      cnt_nxt   = cnt;
      alive_nxt = is_alive;
      vy_sum    = 32'(vy) + 32'(GRAVITY);
      vy_inc    = (vy_sum > 32'(MAX_FALL)) ? VY_W'(MAX_FALL) : VY_W'(vy_sum);

      if (load) begin
         x_nxt     = init_state[X_LSB +: POS_W];
         y_nxt     = init_state[Y_LSB +: POS_W];
         spd_nxt   = init_state[SPD_LSB +: SPD_W];
         dir_nxt   = init_state[DIR_BIT];
         fsm_nxt   = FSM_WALK;
         vy_nxt    = '0;
         cnt_nxt   = '0;
         alive_nxt = 1'b1;
      end else if (frame_tick) begin
         if (stomp && fsm != FSM_DYING) begin
            fsm_nxt = FSM_DYING;
            cnt_nxt = DEATH_LOAD;
         end else begin
            case (fsm)
               FSM_WALK: begin
                  if (!col[COL_GROUND]) begin
                     fsm_nxt = FSM_FALL;
                     vy_nxt  = '0;
                  end else if (wall_hit) begin
                     x_nxt   = x_snapped;
                     dir_nxt = ~dir;
                     if (PAUSE_EN) begin
                        fsm_nxt = FSM_TURN;
                        cnt_nxt = TURN_LOAD;
                     end
                  end else begin
                     x_nxt = x_moved;
                  end
               end
               FSM_TURN: begin
                  if (cnt == '0) fsm_nxt = FSM_WALK;
                  else           cnt_nxt = cnt - 1'b1;
               end
               FSM_FALL: begin
                  if (col[COL_GROUND]) begin
                     y_nxt   = y_land;
                     vy_nxt  = '0;
                     fsm_nxt = FSM_WALK;
                  end else begin
                     vy_nxt = vy_inc;
                     y_nxt  = pos_y + POS_W'(vy_inc);
                  end
               end
               FSM_DYING: begin
                  // DEAD shares the DYING encoding and is frozen until load/reset.
                  if (is_alive) begin
                     if (cnt == '0) alive_nxt = 1'b0;
                     else           cnt_nxt   = cnt - 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign enemy_state = {pos_x, pos_y, speed, fsm, 3'b000, dir, is_alive};
   assign alive       = is_alive;
   assign fsm_state   = fsm;

endmodule

`default_nettype wire

// File: tb/tb_enemy_walker.sv
// ---------------------------------------------------------------------------
// tb_enemy_walker : directed vector table plus multi-cycle sequences
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_enemy_walker;

   logic        sim_clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        load = 1'b0;
   logic        stomp = 1'b0;
   logic [3:0]  col = 4'b0000;
   logic [31:0] init_state = '0;
   logic [31:0] enemy_state, l_enemy_state;
   logic        alive, l_alive;
   logic [1:0]  fsm_state, l_fsm_state;

   int checks = 0;
   int errors = 0;

   always #5 sim_clk = ~sim_clk;

   enemy_walker dut (
      .sim_clk     (sim_clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .load        (load),
      .init_state  (init_state),
      .col         (col),
      .stomp       (stomp),
      .enemy_state (enemy_state),
      .alive       (alive),
      .fsm_state   (fsm_state)
   );

   enemy_walker #(.LEDGE_TURN(1)) dut_l (
      .sim_clk     (sim_clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .load        (load),
      .init_state  (init_state),
      .col         (col),
      .stomp       (stomp),
      .enemy_state (l_enemy_state),
      .alive       (l_alive),
      .fsm_state   (l_fsm_state)
   );

   typedef struct {
      logic       do_ld;
      logic [9:0] lx, ly;
      logic [4:0] ls;
      logic       ldir;
      logic [3:0] c;
      logic       st;
      logic [9:0] ex, ey;
      logic [4:0] es;
      logic [1:0] ef;
      logic       ed, ea;
   } vec_t;

   vec_t vecs[14];
   int   yexp[12] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52, 60, 68};

   function automatic logic [31:0] pk(input logic [9:0] x, input logic [9:0] y, input logic [4:0] s,
                                      input logic [1:0] f, input logic d, input logic a);
      return {x, y, s, f, 3'b000, d, a};
   endfunction

   function automatic vec_t mk(input logic do_ld, input int lx, input int ly, input int ls, input logic ldir,
                               input logic [3:0] c, input logic st, input int ex, input int ey, input int es,
                               input int ef, input logic ed, input logic ea);
      vec_t v;
      v.do_ld = do_ld; v.lx = 10'(lx); v.ly = 10'(ly); v.ls = 5'(ls); v.ldir = ldir;
      v.c = c; v.st = st; v.ex = 10'(ex); v.ey = 10'(ey); v.es = 5'(es); v.ef = 2'(ef);
      v.ed = ed; v.ea = ea;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_dut(input string nm, input int x, input int y, input int s,
                            input int f, input logic d, input logic a);
      check({nm, "/word"}, enemy_state, pk(10'(x), 10'(y), 5'(s), 2'(f), d, a));
      check({nm, "/fsm"}, 32'(fsm_state), 32'(f));
      check({nm, "/alive"}, 32'(alive), 32'(a));
   endtask

   // Load is driven together with a tick and no ground to show load wins.
   task automatic ld(input int x, input int y, input int s, input logic d);
      @(negedge sim_clk);
      init_state = pk(10'(x), 10'(y), 5'(s), 2'b11, d, 1'b0);
      load = 1'b1; frame_tick = 1'b1; col = 4'b0000;
      @(negedge sim_clk);
      load = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic tick(input logic [3:0] c, input logic st);
      @(negedge sim_clk);
      frame_tick = 1'b1; col = c; stomp = st;
      @(negedge sim_clk);
      frame_tick = 1'b0; stomp = 1'b0;
   endtask

   initial begin
      vecs[0]  = mk(0,    0,   0, 0, 0, 4'b1000, 0,  203, 150, 3, 0, 1, 1);
      vecs[1]  = mk(0,    0,   0, 0, 0, 4'b1000, 0,  206, 150, 3, 0, 1, 1);
      vecs[2]  = mk(1,  250, 150, 3, 1, 4'b1010, 0,  223, 150, 3, 1, 0, 1);
      vecs[3]  = mk(1,  100, 150, 3, 0, 4'b1001, 0,  128, 150, 3, 1, 1, 1);
      vecs[4]  = mk(1,  300,  40, 5, 1, 4'b1000, 0,  305,  40, 5, 0, 1, 1);
      vecs[5]  = mk(1,   10,  40, 5, 0, 4'b1000, 0,    5,  40, 5, 0, 0, 1);
      vecs[6]  = mk(1,    2,  40, 5, 0, 4'b1000, 0, 1021,  40, 5, 0, 0, 1);
      vecs[7]  = mk(1, 1020,  40, 5, 1, 4'b1000, 0,    1,  40, 5, 0, 1, 1);
      vecs[8]  = mk(1,   64,  40, 3, 0, 4'b1001, 0,   64,  40, 3, 1, 1, 1);
      vecs[9]  = mk(1,   96,  40, 3, 1, 4'b1010, 0,   95,  40, 3, 1, 0, 1);
      vecs[10] = mk(1,  100, 150, 3, 1, 4'b0000, 0,  100, 150, 3, 2, 1, 1);
      vecs[11] = mk(1,  100, 150, 3, 1, 4'b1100, 0,  103, 150, 3, 0, 1, 1);
      vecs[12] = mk(1,  100, 150, 3, 1, 4'b1000, 1,  100, 150, 3, 3, 1, 1);
      vecs[13] = mk(1,  100, 150, 3, 1, 4'b0011, 0,  100, 150, 3, 2, 1, 1);

      #2 reset = 1'b0;
      repeat (2) @(negedge sim_clk);
      check_dut("reset", 200, 150, 3, 0, 1, 1);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].do_ld) ld(vecs[i].lx, vecs[i].ly, vecs[i].ls, vecs[i].ldir);
         tick(vecs[i].c, vecs[i].st);
         check_dut($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].es,
                   vecs[i].ef, vecs[i].ed, vecs[i].ea);
      end

      // Turn pause: 7 counted ticks stay in TURN, the 8th returns to WALK.
      ld(250, 150, 3, 1);
      tick(4'b1010, 0);
      check_dut("turn_enter", 223, 150, 3, 1, 0, 1);
      for (int k = 1; k <= 7; k++) begin
         tick(4'b1011, 0);
         check_dut($sformatf("turn_hold%0d", k), 223, 150, 3, 1, 0, 1);
      end
      tick(4'b1000, 0);
      check_dut("turn_exit", 223, 150, 3, 0, 0, 1);
      tick(4'b1000, 0);
      check_dut("turn_walk", 220, 150, 3, 0, 0, 1);

      // Fall and land.
      ld(100, 150, 3, 1);
      tick(4'b0000, 0);
      check_dut("fall_enter", 100, 150, 3, 2, 1, 1);
      tick(4'b0011, 0); check_dut("fall1", 100, 151, 3, 2, 1, 1);
      tick(4'b0011, 0); check_dut("fall2", 100, 153, 3, 2, 1, 1);
      tick(4'b0011, 0); check_dut("fall3", 100, 156, 3, 2, 1, 1);
      tick(4'b1000, 0); check_dut("land", 100, 128, 3, 0, 1, 1);

      // Terminal velocity.
      ld(100, 0, 3, 1);
      tick(4'b0000, 0);
      for (int k = 0; k < 12; k++) begin
         tick(4'b0000, 0);
         check($sformatf("vmax_y%0d", k), 32'(enemy_state[21:12]), 32'(yexp[k]));
      end

      // Ledge turn only on the LEDGE_TURN=1 instance.
      ld(100, 150, 3, 1);
      tick(4'b1100, 0);
      check_dut("ledge_off", 103, 150, 3, 0, 1, 1);
      check("ledge_on/word", l_enemy_state, pk(10'd95, 10'd150, 5'd3, 2'd1, 1'b0, 1'b1));

      // Stomp during TURN, death countdown, then DEAD is inert.
      ld(250, 150, 3, 1);
      tick(4'b1010, 0);
      tick(4'b1000, 1);
      check_dut("stomp", 223, 150, 3, 3, 0, 1);
      for (int k = 1; k <= 15; k++) begin
         tick(4'b1011, 0);
         check_dut($sformatf("dying%0d", k), 223, 150, 3, 3, 0, 1);
      end
      tick(4'b1000, 0);
      check_dut("dead", 223, 150, 3, 3, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tick(4'b0011, 1);
         check_dut($sformatf("dead_hold%0d", k), 223, 150, 3, 3, 0, 0);
      end

      // No tick means hold; load mid-DYING revives.
      ld(100, 150, 3, 1);
      tick(4'b1000, 1);
      repeat (3) tick(4'b1000, 0);
      repeat (3) @(negedge sim_clk);
      check_dut("idle_hold", 100, 150, 3, 3, 1, 1);
      ld(50, 60, 2, 0);
      check_dut("load_dying", 50, 60, 2, 0, 0, 1);

      // Asynchronous reset mid-FALL, away from any clock edge.
      ld(100, 150, 3, 1);
      tick(4'b0000, 0);
      tick(4'b0000, 0);
      check_dut("pre_reset", 100, 151, 3, 2, 1, 1);
      @(posedge sim_clk);
      #2 reset = 1'b0;
      #1 check_dut("async_reset", 200, 150, 3, 0, 1, 1);
      check("async_reset_l", l_enemy_state, pk(10'd200, 10'd150, 5'd3, 2'd0, 1'b1, 1'b1));
      @(negedge sim_clk);
      reset = 1'b1;
      tick(4'b1000, 0);
      check_dut("post_reset", 203, 150, 3, 0, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
